// File: rtl/cordic_delay_line.sv
// cordic_delay_line
//
// Runtime-programmable alignment delay for the CORDIC datapath. NUM_CH signed
// samples are delayed together through a ring buffer. A valid flag travels
// with each sample, and the registered output has an enable gate. After reset
// or a reconfiguration, the line primes for cur_delay cycles. During priming,
// stale contents are masked from the output.
//
// Optional build macro: CORDIC_DELAY_STATS_EN adds drop_count_o, a saturating
// count of valid samples that were suppressed or discarded.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   enable_i      output gate (0 forces out_data_o/out_valid_o to 0)
//   cfg_load_i    one-cycle strobe that loads cfg_delay_i (clamped to 1..MAX_DELAY)
//   cfg_delay_i   requested delay in cycles
//   in_valid_i    in_data_i carries a sample this cycle
//   in_data_i     channel k at [k*SIZE_DATA +: SIZE_DATA]
//   out_valid_o   out_data_o carries a delayed sample
//   out_data_o    delayed samples, same packing as in_data_i
//   primed_o      line filled at the current delay
//   cur_delay_o   delay in force after clamping
//   drop_count_o  (CORDIC_DELAY_STATS_EN only) suppressed/discarded valid samples

module cordic_delay_line #(
    parameter int unsigned SIZE_DATA     = 16,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned MAX_DELAY     = 32,
    parameter int unsigned DELAY_W       = 6,
    parameter int unsigned DEFAULT_DELAY = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic                          cfg_load_i,
    input  logic [DELAY_W-1:0]            cfg_delay_i,
    input  logic                          in_valid_i,
    input  logic [NUM_CH*SIZE_DATA-1:0]   in_data_i,
    output logic                          out_valid_o,
    output logic [NUM_CH*SIZE_DATA-1:0]   out_data_o,
    output logic                          primed_o,
    output logic [DELAY_W-1:0]            cur_delay_o
`ifdef CORDIC_DELAY_STATS_EN
    ,
    output logic [15:0]                   drop_count_o
`endif
);

    localparam int unsigned DataW = NUM_CH * SIZE_DATA;
    localparam int unsigned PtrW  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef enum logic {StPrime, StRun} state_e;

    logic [DataW-1:0]   mem_data_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] mem_vld_q;

    logic [PtrW-1:0]    wptr_q, wptr_d, rptr;
    state_e             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               primed_q, primed_d;
    logic               out_valid_q, out_valid_d;
    logic [DataW-1:0]   out_data_q, out_data_d;

    logic [DELAY_W-1:0] delay_clamped;
    logic [DELAY_W:0]   wptr_ext, delay_ext, rsum;
    logic [DataW-1:0]   rd_data;
    logic               rd_vld;
    logic               pass;

    // Clamp a requested delay into 1..MAX_DELAY.
    always_comb begin
        delay_clamped = cfg_delay_i;
        if (cfg_delay_i == '0) begin
            delay_clamped = DELAY_W'(1);
        end else if (32'(cfg_delay_i) > MAX_DELAY) begin
            delay_clamped = DELAY_W'(MAX_DELAY);
        end
    end

    // Read index = wptr - delay (mod MAX_DELAY). The read happens before the
    // write, so D = MAX_DELAY returns the entry about to be overwritten.
    always_comb begin
        wptr_ext  = (DELAY_W+1)'(wptr_q);
        delay_ext = {1'b0, delay_q};
        if (wptr_ext >= delay_ext) begin
            rsum = wptr_ext - delay_ext;
        end else begin
            rsum = wptr_ext + (DELAY_W+1)'(MAX_DELAY) - delay_ext;
        end
        rptr = PtrW'(rsum);
    end

    assign rd_data = mem_data_q[rptr];
    assign rd_vld  = mem_vld_q[rptr];

    always_comb begin
        wptr_d = (wptr_q == PtrW'(MAX_DELAY - 1)) ? '0 : wptr_q + PtrW'(1);
    end

    // Data is stored every cycle. Valid is cleared for a sample arriving with cfg_load.
    always_ff @(posedge clk) begin
        mem_data_q[wptr_q] <= in_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_vld_q <= '0;
        end else begin
            mem_vld_q[wptr_q] <= in_valid_i & ~cfg_load_i;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        delay_d  = delay_q;
        primed_d = primed_q;

        if (cfg_load_i) begin
            state_d  = StPrime;
            cnt_d    = '0;
            primed_d = 1'b0;
            delay_d  = delay_clamped;
        end else begin
            unique case (state_q)
                StPrime: begin
                    cnt_d = cnt_q + DELAY_W'(1);
                    if (cnt_d == delay_q) begin
                        state_d  = StRun;
                        primed_d = 1'b1;
                    end
                end
                StRun: begin
                    state_d = StRun;
                end
                default: begin
                    state_d = StPrime;
                end
            endcase
        end

        // The read on a cfg_load edge is an in-flight sample and is masked as well.
        pass        = (state_q == StRun) & ~cfg_load_i & enable_i;
        out_valid_d = pass & rd_vld;
        out_data_d  = pass ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            state_q     <= StPrime;
            cnt_q       <= '0;
            delay_q     <= DELAY_W'(DEFAULT_DELAY);
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            delay_q     <= delay_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign primed_o    = primed_q;
    assign cur_delay_o = delay_q;

`ifdef CORDIC_DELAY_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // Up to two drops per cycle: a masked valid read plus a discarded input.
    always_comb begin
        drop_inc = {1'b0, rd_vld & ~pass} + {1'b0, in_valid_i & cfg_load_i};
        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count_o = drop_q;
`endif

endmodule
